// File: rtl/nrisc_pkg.sv
// Shared nRisc definitions: opcodes, instruction field positions and fetch FSM states.
package nrisc_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LI  = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 5;
    localparam int RA_MSB = 4;
    localparam int RA_LSB = 2;
    localparam int RB_MSB = 1;
    localparam int RB_LSB = 0;

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        RUN   = 3'd1,
        IMM   = 3'd2,
        JWAIT = 3'd3,
        REDIR = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_split.sv
// Combinational split of an 8-bit nRisc word into opcode and register fields.
module instr_split
    import nrisc_pkg::*;
(
    input  logic [7:0] word,
    output logic [2:0] op,
    output logic [2:0] ra,
    output logic [2:0] rb
);

    assign op = word[OP_MSB:OP_LSB];
    assign ra = word[RA_MSB:RA_LSB];
    assign rb = {1'b0, word[RB_MSB:RB_LSB]};

endmodule

// File: rtl/fetch_unit.sv
// nRisc instruction fetch: PC, ROM-latency fill, LI immediate pass-through and JMP freeze/redirect.
module fetch_unit
    import nrisc_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_rdata,
    output logic [2:0]        operation,
    output logic [2:0]        reg_a,
    output logic [2:0]        reg_b,
    output logic [7:0]        data,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              jumped
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        operation_q, operation_d;
    logic [2:0]        reg_a_q, reg_a_d;
    logic [2:0]        reg_b_q, reg_b_d;
    logic [7:0]        data_q, data_d;
    logic              jumped_q, jumped_d;

    logic [2:0] dec_op, dec_ra, dec_rb;

    instr_split u_split (
        .word (imem_rdata),
        .op   (dec_op),
        .ra   (dec_ra),
        .rb   (dec_rb)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        operation_d = operation_q;
        reg_a_d     = reg_a_q;
        reg_b_d     = reg_b_q;
        data_d      = data_q;
        jumped_d    = jumped_q;
        if (!stall) begin
            // Every non-stalled cycle starts from a bubble; only RUN and IMM put a word out.
            operation_d = OP_NOP;
            reg_a_d     = '0;
            reg_b_d     = '0;
            data_d      = '0;
            jumped_d    = 1'b0;
            case (state_q)
                FILL: begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = RUN;
                end
                RUN: begin
                    operation_d = dec_op;
                    reg_a_d     = dec_ra;
                    reg_b_d     = dec_rb;
                    data_d      = imem_rdata;
                    if (dec_op == OP_JMP) begin
                        state_d = JWAIT;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                        if (dec_op == OP_LI) state_d = IMM;
                    end
                end
                IMM: begin
                    data_d  = imem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = RUN;
                end
                JWAIT: begin
                    if (branch_valid) begin
                        pc_d     = branch_target;
                        jumped_d = 1'b1;
                        state_d  = REDIR;
                    end
                end
                REDIR: begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = RUN;
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            pc_q        <= RESET_PC;
            operation_q <= OP_NOP;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            data_q      <= '0;
            jumped_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            operation_q <= operation_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            data_q      <= data_d;
            jumped_q    <= jumped_d;
        end
    end

    assign imem_addr = pc_q;
    assign operation = operation_q;
    assign reg_a     = reg_a_q;
    assign reg_b     = reg_b_q;
    assign data      = data_q;
    assign jumped    = jumped_q;

endmodule
